// File: rtl/vga_pkg.sv
// Shared VGA timing constants, polarity codes and helpers for the grayblastVGA tile.
package vga_pkg;

    localparam int unsigned H_ACTIVE_640 = 640;
    localparam int unsigned H_FP_640     = 16;
    localparam int unsigned H_SYNC_640   = 96;
    localparam int unsigned H_BP_640     = 48;
    localparam int unsigned V_ACTIVE_480 = 480;
    localparam int unsigned V_FP_480     = 10;
    localparam int unsigned V_SYNC_480   = 2;
    localparam int unsigned V_BP_480     = 33;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    typedef enum logic [1:0] {
        RGN_ACTIVE,
        RGN_FP,
        RGN_SYNC,
        RGN_BP
    } axis_region_e;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus look-ahead sync/active decode
// of the value it will hold after the current edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = H_ACTIVE_640,
    parameter int unsigned FP     = H_FP_640,
    parameter int unsigned SYNC   = H_SYNC_640,
    parameter int unsigned BP     = H_BP_640,
    parameter logic        POL    = POL_LOW,
    parameter int unsigned CW     = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_advance,
    output logic          o_wrap,
    output logic [CW-1:0] o_next_count,
    output logic          o_next_sync,
    output logic          o_next_active
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (FP == 0 || SYNC == 0 || BP == 0) begin : g_err_region
        $error("vga_axis_counter: porch and sync lengths must be non-zero");
    end
    if (64'(TOTAL) > (64'd1 << CW)) begin : g_err_width
        $error("vga_axis_counter: axis total does not fit in CW bits");
    end

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_next;
    logic          w_at_last;
    axis_region_e  w_region;

    always_comb begin
        w_at_last = (r_count == LAST);
        o_wrap    = i_advance & w_at_last;
        w_next    = r_count;
        if (i_advance) begin
            w_next = w_at_last ? '0 : r_count + CW'(1);
        end
    end

    // Region decode runs on the next value so the registered outputs line up
    // with the counter they describe.
    always_comb begin
        w_region = RGN_BP;
        if (w_next < ACT_END) begin
            w_region = RGN_ACTIVE;
        end else if (w_next < SYNC_START) begin
            w_region = RGN_FP;
        end else if (w_next < SYNC_END) begin
            w_region = RGN_SYNC;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= LAST;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_next_count  = w_next;
    assign o_next_sync   = (w_region == RGN_SYNC) ? POL : ~POL;
    assign o_next_active = (w_region == RGN_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: prescaled pixel tick, two axis
// counters, registered syncs/DE/coordinates and line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_640,
    parameter int unsigned H_FP       = H_FP_640,
    parameter int unsigned H_SYNC     = H_SYNC_640,
    parameter int unsigned H_BP       = H_BP_640,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_480,
    parameter int unsigned V_FP       = V_FP_480,
    parameter int unsigned V_SYNC     = V_SYNC_480,
    parameter int unsigned V_BP       = V_BP_480,
    parameter logic        H_POL      = POL_LOW,
    parameter logic        V_POL      = POL_LOW,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned CW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    if (CLK_DIV < 1) begin : g_err_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    localparam int unsigned   PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_p;
    logic          w_tick;

    logic          w_h_wrap;
    logic [CW-1:0] w_h_next;
    logic          w_h_sync;
    logic          w_h_act;
    logic          w_v_wrap;
    logic [CW-1:0] w_v_next;
    logic          w_v_sync;
    logic          w_v_act;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    assign w_tick = en & (r_p == P_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else if (en) begin
            r_p <= (r_p == P_LAST) ? '0 : r_p + PW'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .CW     (CW)
    ) u_hcnt (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_advance     (w_tick),
        .o_wrap        (w_h_wrap),
        .o_next_count  (w_h_next),
        .o_next_sync   (w_h_sync),
        .o_next_active (w_h_act)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .CW     (CW)
    ) u_vcnt (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_advance     (w_h_wrap),
        .o_wrap        (w_v_wrap),
        .o_next_count  (w_v_next),
        .o_next_sync   (w_v_sync),
        .o_next_active (w_v_act)
    );

    // Position 0 on an axis is only ever entered by wrapping, so the wrap
    // pulses (already qualified by the tick) are exactly the entry strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_h_sync;
            r_vsync       <= w_v_sync;
            r_de          <= w_h_act & w_v_act;
            r_x           <= w_h_act ? (w_h_next >> SCALE_LOG2) : '0;
            r_y           <= w_v_act ? (w_v_next >> SCALE_LOG2) : '0;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign pix_tick    = w_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing, a tiny raster with an
// enable gap and mid-frame reset, and a divided/downscaled tiny raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, tick_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       rst_b, en_b, tick_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       rst_c, en_c, tick_c, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(tick_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .pix_tick(tick_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CLK_DIV(3), .SCALE_LOG2(1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .pix_tick(tick_c),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .x(x_c), .y(y_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        int         n;
        logic       tick;
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int n;
        int first_hs;
        int hs_low;
        int de_hi;
        int ls_cnt;
        int ticks;
        int h;

        // Small raster: H 8/2/3/2 (total 15), V 4/1/1/1 (total 7), hsync active high.
        //           rst en  n   tick hs vs de  x  y  ls fs
        tbl[0]  = '{1, 1, 2,  1, 0, 1, 0, 0, 0, 0, 0};  // reset state
        tbl[1]  = '{0, 1, 1,  1, 0, 1, 1, 0, 0, 1, 1};  // (0,0)
        tbl[2]  = '{0, 1, 1,  1, 0, 1, 1, 1, 0, 0, 0};  // (1,0)
        tbl[3]  = '{0, 0, 5,  0, 0, 1, 1, 1, 0, 0, 0};  // frozen at (1,0)
        tbl[4]  = '{0, 1, 1,  1, 0, 1, 1, 2, 0, 0, 0};  // (2,0) no skip
        tbl[5]  = '{0, 1, 7,  1, 0, 1, 0, 0, 0, 0, 0};  // (9,0) front porch
        tbl[6]  = '{0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 0};  // (10,0) sync start
        tbl[7]  = '{0, 1, 2,  1, 1, 1, 0, 0, 0, 0, 0};  // (12,0) sync end
        tbl[8]  = '{0, 1, 1,  1, 0, 1, 0, 0, 0, 0, 0};  // (13,0) back porch
        tbl[9]  = '{0, 1, 2,  1, 0, 1, 1, 0, 1, 1, 0};  // (0,1)
        tbl[10] = '{0, 0, 1,  0, 0, 1, 1, 0, 1, 0, 0};  // held, strobe dropped
        tbl[11] = '{0, 1, 1,  1, 0, 1, 1, 1, 1, 0, 0};  // (1,1)
        tbl[12] = '{0, 1, 59, 1, 0, 0, 0, 0, 0, 1, 0};  // (0,5) vsync
        tbl[13] = '{0, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0};  // (14,5)
        tbl[14] = '{0, 1, 1,  1, 0, 1, 0, 0, 0, 1, 0};  // (0,6)
        tbl[15] = '{0, 1, 14, 1, 0, 1, 0, 0, 0, 0, 0};  // (14,6)
        tbl[16] = '{0, 1, 1,  1, 0, 1, 1, 0, 0, 1, 1};  // (0,0) new frame
        tbl[17] = '{0, 1, 3,  1, 0, 1, 1, 3, 0, 0, 0};  // (3,0)
        tbl[18] = '{1, 0, 1,  0, 0, 1, 0, 0, 0, 0, 0};  // reset beats en=0
        tbl[19] = '{0, 1, 1,  1, 0, 1, 1, 0, 0, 1, 1};  // (0,0)

        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1;
        rst_c = 1'b1; en_c = 1'b1;

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                rst_b = tbl[i].rst;
                en_b  = tbl[i].en;
                step();
            end
            check($sformatf("b_v%0d_tick", i), 32'(tick_b), 32'(tbl[i].tick));
            check($sformatf("b_v%0d_hsync", i), 32'(hs_b), 32'(tbl[i].hs));
            check($sformatf("b_v%0d_vsync", i), 32'(vs_b), 32'(tbl[i].vs));
            check($sformatf("b_v%0d_de", i), 32'(de_b), 32'(tbl[i].de));
            check($sformatf("b_v%0d_x", i), 32'(x_b), 32'(tbl[i].x));
            check($sformatf("b_v%0d_y", i), 32'(y_b), 32'(tbl[i].y));
            check($sformatf("b_v%0d_line_start", i), 32'(ls_b), 32'(tbl[i].ls));
            check($sformatf("b_v%0d_frame_start", i), 32'(fs_b), 32'(tbl[i].fs));
        end

        // Small raster frame period: 15 * 7 clks.
        n = 0;
        do begin
            step();
            n++;
        end while (!fs_b && n < 200);
        check("b_frame_period", 32'(n), 32'd105);

        // Default 640x480 timing over one full line.
        rst_a = 1'b0;
        step();
        check("a_first_frame_start", 32'(fs_a), 32'd1);
        check("a_first_de", 32'(de_a), 32'd1);
        first_hs = -1;
        hs_low   = 0;
        de_hi    = 1;
        ls_cnt   = 0;
        for (int k = 1; k <= 800; k++) begin
            step();
            if (k < 800) begin
                if (!hs_a) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = k;
                end
                if (de_a) de_hi++;
                if (ls_a) ls_cnt++;
            end
            if (k == 639) check("a_x_last_active", 32'(x_a), 32'd639);
            if (k == 640) check("a_x_blank", 32'(x_a), 32'd0);
        end
        check("a_line_period_ls", 32'(ls_a), 32'd1);
        check("a_y_line1", 32'(y_a), 32'd1);
        check("a_ls_inside_line", 32'(ls_cnt), 32'd0);
        check("a_hsync_first_low", 32'(first_hs), 32'd656);
        check("a_hsync_low_clks", 32'(hs_low), 32'd96);
        check("a_de_high_clks", 32'(de_hi), 32'd640);
        check("a_vsync_idle", 32'(vs_a), 32'd1);

        repeat (100) step();
        check("a_x_before_rst", 32'(x_a), 32'd100);
        en_a  = 1'b0;
        rst_a = 1'b1;
        step();
        check("a_rst_de", 32'(de_a), 32'd0);
        check("a_rst_hsync", 32'(hs_a), 32'd1);
        check("a_rst_vsync", 32'(vs_a), 32'd1);
        check("a_rst_x", 32'(x_a), 32'd0);
        check("a_rst_y", 32'(y_a), 32'd0);
        rst_a = 1'b0;
        en_a  = 1'b1;
        step();
        check("a_rst_release_fs", 32'(fs_a), 32'd1);
        check("a_rst_release_ls", 32'(ls_a), 32'd1);
        check("a_rst_release_x", 32'(x_a), 32'd0);
        check("a_rst_release_y", 32'(y_a), 32'd0);

        // Divided (CLK_DIV=3) and downscaled (SCALE_LOG2=1) small raster.
        rst_c = 1'b0;
        n = 0;
        while (!fs_c && n < 20) begin
            step();
            n++;
        end
        check("c_first_fs_latency", 32'(n), 32'd3);
        check("c_fs_tick_phase", 32'(tick_c), 32'd0);
        ticks = 0;
        for (int k = 1; k <= 90; k++) begin
            step();
            h = (k / 3) % 15;
            if (tick_c) ticks++;
            check($sformatf("c_x_k%0d", k), 32'(x_c), (h < 8) ? 32'(h >> 1) : 32'd0);
            check($sformatf("c_ls_k%0d", k), 32'(ls_c), (k % 45 == 0) ? 32'd1 : 32'd0);
        end
        check("c_tick_count", 32'(ticks), 32'd30);
        check("c_y_line2", 32'(y_c), 32'd1);
        check("c_fs_not_repeated", 32'(fs_c), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator for the grayblastVGA tile. It is the next generation of the fixed 640x480 timing core.
- Generates hsync, vsync, data-enable and pixel coordinates, plus line and frame strobes.
- Adds three things: a pixel-clock prescaler, power-of-two coordinate downscaling, and a run enable.
- Sits between the top-level tile wrapper and the pixel/colour pipeline. uo_out sync bits are driven directly from its registered outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active low)
- V_POL, 0, vsync active level (0 = active low)
- CLK_DIV, 1, clk cycles per pixel tick (>=1)
- SCALE_LOG2, 0, logical coordinate = raw counter >> SCALE_LOG2
- CW, 10, counter/coordinate width; H_TOTAL and V_TOTAL must be <= 2^CW

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- en  in  1  run enable; low freezes timing
- pix_tick  out  1  high on clk cycles where the raster advances (combinational from prescaler, gated by en)
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- de  out  1  registered display enable (active pixel)
- x  out  CW  registered logical column
- y  out  CW  registered logical row
- line_start  out  1  one-clk pulse on entering hcount=0
- frame_start  out  1  one-clk pulse on entering (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Region order per axis: active, front porch, sync, back porch.
- Prescaler p counts 0..CLK_DIV-1 while en=1. pix_tick = en & (p==CLK_DIV-1). With CLK_DIV=1, pix_tick = en.
- On a pix_tick edge:
  - hcount advances and wraps H_TOTAL-1 -> 0.
  - On hcount wrap, vcount advances and wraps V_TOTAL-1 -> 0.
- All outputs except pix_tick are registered from the next-state counters. After any edge they therefore describe the current (hcount,vcount). Latency 0 relative to the counters; outputs hold between ticks.
- hsync = H_POL when hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~H_POL.
- vsync = V_POL when vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~V_POL. vsync changes aligned with hcount=0.
- de = (hcount < H_ACTIVE) & (vcount < V_ACTIVE).
- x = hcount>>SCALE_LOG2 when hcount < H_ACTIVE, else 0. y = vcount>>SCALE_LOG2 when vcount < V_ACTIVE, else 0.
- line_start and frame_start are high for exactly one clk after the tick edge that enters the position. With CLK_DIV>1 they are still one clk wide.
- Reset values:
  - p=0; hcount=H_TOTAL-1; vcount=V_TOTAL-1 (last back-porch pixel).
  - hsync=~H_POL, vsync=~V_POL, de=0, x=0, y=0, line_start=0, frame_start=0.
- The first tick after reset enters (0,0): de=1, line_start=1, frame_start=1.
- en=0: p, the counters and all registered outputs hold. Strobes are forced to 0. pix_tick=0. Resuming continues from the held phase with no skipped or duplicated pixel.
- rst mid-frame: all state returns to the reset values on that edge, regardless of en. rst has priority over en.
- Elaboration error if CLK_DIV<1, any porch/sync parameter is 0, or H_TOTAL/V_TOTAL > 2^CW.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants (H_ACTIVE_640 ... V_BP_480);
  - polarity constants POL_LOW=0, POL_HIGH=1;
  - a function computing the total from the four region lengths.
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - parameters: ACTIVE, FP, SYNC, BP, POL, CW;
  - inputs: advance;
  - outputs: wrap, next-count, next-sync, next-active.
- The top level holds the prescaler, output registers and strobes.

Test Plan:
- Defaults, en=1, rst released at cycle 0 -> frame_start at clk 1; consecutive line_start 800 clks apart; consecutive frame_start 420000 clks apart.
- Defaults -> hsync low exactly for hcount 656..751 (96 clks), de high 640 clks per active line; vsync low for lines 490..491 (1600 clks).
- CLK_DIV=3 -> each pixel held 3 clks; pix_tick 1-in-3; line_start still one clk wide; line period 2400 clks.
- SCALE_LOG2=1 -> x counts 0,0,1,1,...,319,319 then 0 in blanking; y max 239.
- Small mode (H 8/2/3/2, V 4/1/1/1, H_POL=1), en dropped for 5 clks mid-line -> all outputs frozen, strobes 0, sequence resumes without gap; hsync high for hcount 10..12.
- rst pulsed at hcount=300, vcount=200 -> next clk has de=0, syncs inactive, x=y=0. First tick after release gives frame_start=1 with x=0, y=0.
